// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader path.
// Segment patterns are abcdefg with bit 6 = segment a, 1 = lit.
// Optional feature macro: SEG7_READER_HEX_EN (hex letters A-F decode as legal).
package seg7_pkg;

    // Decimal digit patterns
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;

    // All segments dark
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Hex letter patterns (A, b, C, d, E, F)
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;

    // Value reported for anything that is not a digit or enabled letter
    localparam logic [3:0] VAL_NONE  = 4'hF;

    // Capture FSM:
    //   S_WAIT  - no valid (one-hot select) sample present
    //   S_COUNT - counting consecutive identical valid samples
    //   S_DONE  - current sample already captured, waiting for it to change
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/m_7seg_decode.sv
// Combinational seven-segment pattern decoder.
// Produces a 4-bit value plus illegal / blank flags for one pattern.
// Optional feature macro: SEG7_READER_HEX_EN (letters A-F decode to 4'hA..4'hF).
module m_7seg_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_err,
    output logic       o_blank
);

    // Pattern lookup; anything unrecognised is illegal and reads as 4'hF
    always_comb begin
        o_value = VAL_NONE;
        o_err   = 1'b1;
        o_blank = 1'b0;
        case (i_pattern)
            SEG_0: begin o_value = 4'h0; o_err = 1'b0; end
            SEG_1: begin o_value = 4'h1; o_err = 1'b0; end
            SEG_2: begin o_value = 4'h2; o_err = 1'b0; end
            SEG_3: begin o_value = 4'h3; o_err = 1'b0; end
            SEG_4: begin o_value = 4'h4; o_err = 1'b0; end
            SEG_5: begin o_value = 4'h5; o_err = 1'b0; end
            SEG_6: begin o_value = 4'h6; o_err = 1'b0; end
            SEG_7: begin o_value = 4'h7; o_err = 1'b0; end
            SEG_8: begin o_value = 4'h8; o_err = 1'b0; end
            SEG_9: begin o_value = 4'h9; o_err = 1'b0; end
            SEG_BLANK: begin
                o_value = VAL_NONE;
                o_err   = 1'b0;
                o_blank = 1'b1;
            end
`ifdef SEG7_READER_HEX_EN
            SEG_A: begin o_value = 4'hA; o_err = 1'b0; end
            SEG_B: begin o_value = 4'hB; o_err = 1'b0; end
            SEG_C: begin o_value = 4'hC; o_err = 1'b0; end
            SEG_D: begin o_value = 4'hD; o_err = 1'b0; end
            SEG_E: begin o_value = 4'hE; o_err = 1'b0; end
            SEG_F: begin o_value = 4'hF; o_err = 1'b0; end
`else
            // Without hex support the letters fall through to the illegal default
`endif
            default: begin
                o_value = VAL_NONE;
                o_err   = 1'b1;
                o_blank = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/m_7seg_reader.sv
// Observer for a multiplexed seven-segment display bus.
// Registers {w_sel, w_seg} every cycle, waits for a one-hot select and an
// unchanged pattern for STABLE consecutive samples, then decodes the pattern
// into the selected digit's value/err/blank registers. A captured-digit mask
// produces a one-cycle w_frame when every digit has been captured.
// Optional feature macro: SEG7_READER_HEX_EN (letters A-F decode as legal).
//
// There is no handshake: the bus is sampled unconditionally every cycle and
// w_frame is a single-cycle, registered strobe aligned with the output update
// of the capture that completed the frame.
module m_7seg_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic [6:0]            w_seg,
    input  logic [DIGITS-1:0]     w_sel,
    output logic [4*DIGITS-1:0]   w_val,
    output logic [DIGITS-1:0]     w_err,
    output logic [DIGITS-1:0]     w_blank,
    output logic                  w_frame
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    // Sample register and the sample from one cycle earlier
    logic [DIGITS-1:0]   r_sel;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_prev_sel;
    logic [6:0]          r_prev_seg;

    // FSM, stability counter and captured-digit mask
    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [DIGITS-1:0]   r_mask;

    // Per-digit output registers
    logic [4*DIGITS-1:0] r_val;
    logic [DIGITS-1:0]   r_err;
    logic [DIGITS-1:0]   r_blank;
    logic                r_frame;

    // Combinational helpers
    logic                w_valid;
    logic                w_same;
    logic [3:0]          w_cnt_inc;
    logic                w_capture;
    state_t              w_state_nx;
    logic [3:0]          w_cnt_nx;
    logic [DIGITS-1:0]   w_mask_set;
    logic [3:0]          w_dec_val;
    logic                w_dec_err;
    logic                w_dec_blank;

    // A sample is only meaningful when exactly one digit is selected
    assign w_valid   = $onehot(r_sel);
    assign w_same    = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);
    // Saturating increment; the counter never passes STABLE
    assign w_cnt_inc = (r_cnt >= STABLE_C) ? STABLE_C : (r_cnt + 4'd1);
    // Capture on the edge where the run of identical samples reaches STABLE
    assign w_capture = (r_state == S_COUNT) && w_valid && w_same &&
                       (w_cnt_inc == STABLE_C);
    assign w_mask_set = r_mask | r_sel;

    m_7seg_decode u_decode (
        .i_pattern (r_seg),
        .o_value   (w_dec_val),
        .o_err     (w_dec_err),
        .o_blank   (w_dec_blank)
    );

    // Capture FSM next-state and counter logic
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (w_valid) begin
                    w_state_nx = S_COUNT;
                    w_cnt_nx   = 4'd1;
                end else begin
                    w_cnt_nx   = 4'd0;
                end
            end
            S_COUNT: begin
                if (!w_valid) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = 4'd0;
                end else if (w_same) begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == STABLE_C) begin
                        w_state_nx = S_DONE;
                    end
                end else begin
                    w_cnt_nx = 4'd1;
                end
            end
            S_DONE: begin
                if (!w_valid) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = 4'd0;
                end else if (!w_same) begin
                    w_state_nx = S_COUNT;
                    w_cnt_nx   = 4'd1;
                end
            end
            default: begin
                w_state_nx = S_WAIT;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    // Bus sampling pipeline
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_sel      <= '0;
            r_seg      <= '0;
            r_prev_sel <= '0;
            r_prev_seg <= '0;
        end else begin
            r_sel      <= w_sel;
            r_seg      <= w_seg;
            r_prev_sel <= r_sel;
            r_prev_seg <= r_seg;
        end
    end

    // FSM state and stability counter
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S_WAIT;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Per-digit capture, captured mask and frame strobe
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_val   <= '0;
            r_err   <= '0;
            r_blank <= '0;
            r_mask  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (w_capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_sel[i]) begin
                        r_val[4*i +: 4] <= w_dec_val;
                        r_err[i]        <= w_dec_err;
                        r_blank[i]      <= w_dec_blank;
                    end
                end
                // Completing the set fires the strobe and starts a new frame
                if (&w_mask_set) begin
                    r_mask  <= '0;
                    r_frame <= 1'b1;
                end else begin
                    r_mask  <= w_mask_set;
                end
            end
        end
    end

    assign w_val   = r_val;
    assign w_err   = r_err;
    assign w_blank = r_blank;
    assign w_frame = r_frame;

endmodule

// File: tb/tb_m_7seg_reader.sv
// Self-checking bench for m_7seg_reader: directed scenarios followed by
// randomized bus traffic, all compared every cycle against a run-length
// based reference model, plus literal checks at scenario boundaries.
module tb_m_7seg_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;
`ifdef SEG7_READER_HEX_EN
    localparam int LEGAL_N = 16;
`else
    localparam int LEGAL_N = 10;
`endif

    // ---------------- clock / reset ----------------
    logic        w_clk = 1'b0;
    logic        w_rst;
    logic [6:0]  w_seg;
    logic [3:0]  w_sel;
    logic [15:0] w_val;
    logic [3:0]  w_err;
    logic [3:0]  w_blank;
    logic        w_frame;

    always #5 w_clk = ~w_clk;

    m_7seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_seg   (w_seg),
        .w_sel   (w_sel),
        .w_val   (w_val),
        .w_err   (w_err),
        .w_blank (w_blank),
        .w_frame (w_frame)
    );

    int total = 0;
    int bad = 0;
    int frame_seen = 0;
    bit chk_en = 1'b0;

    // Patterns for values 0..15 (0-9 digits, A-F letters)
    logic [6:0] pat_tab [16];

    // ---------------- reference model ----------------
    logic [15:0] m_val;
    logic [3:0]  m_err;
    logic [3:0]  m_blank;
    logic        m_frame;
    logic [3:0]  m_mask;
    int          run_len;
    logic [3:0]  prev_sel;
    logic [6:0]  prev_seg;
    bit          pend;
    logic [3:0]  pend_sel;
    logic [6:0]  pend_seg;

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v,
                                       output logic e, output logic b);
        v = 4'hF;
        e = 1'b1;
        b = 1'b0;
        if (p == 7'b0000000) begin
            e = 1'b0;
            b = 1'b1;
        end
        for (int k = 0; k < LEGAL_N; k++) begin
            if (pat_tab[k] == p) begin
                v = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    function automatic int ones(input logic [3:0] s);
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(s[k]);
        return n;
    endfunction

    // A valid input captured after exactly STABLE identical one-hot samples;
    // the capture shows up one edge after the sample that completes the run.
    always @(posedge w_clk) begin
        logic [3:0] v;
        logic       e;
        logic       b;
        if (w_rst) begin
            m_val = '0; m_err = '0; m_blank = '0; m_frame = 1'b0; m_mask = '0;
            run_len = 0; prev_sel = '0; prev_seg = '0; pend = 1'b0;
        end else begin
            m_frame = 1'b0;
            if (pend) begin
                ref_decode(pend_seg, v, e, b);
                for (int d = 0; d < 4; d++) begin
                    if (pend_sel[d]) begin
                        m_val[4*d +: 4] = v;
                        m_err[d]        = e;
                        m_blank[d]      = b;
                    end
                end
                m_mask = m_mask | pend_sel;
                if (m_mask == 4'hF) begin
                    m_frame = 1'b1;
                    m_mask  = '0;
                end
                pend = 1'b0;
            end
            if (ones(w_sel) != 1) run_len = 0;
            else if (run_len > 0 && w_sel == prev_sel && w_seg == prev_seg) begin
                if (run_len < 1000) run_len++;
            end else run_len = 1;
            prev_sel = w_sel;
            prev_seg = w_seg;
            if (run_len == STABLE) begin
                pend     = 1'b1;
                pend_sel = w_sel;
                pend_seg = w_seg;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge w_clk) begin
        if (w_frame === 1'b1) frame_seen++;
        if (chk_en) begin
            chk("cyc_val",   32'(w_val),   32'(m_val));
            chk("cyc_err",   32'(w_err),   32'(m_err));
            chk("cyc_blank", 32'(w_blank), 32'(m_blank));
            chk("cyc_frame", 32'(w_frame), 32'(m_frame));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) begin
            w_sel = sel;
            w_seg = seg;
            @(posedge w_clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        drive(4'b0001, p0, STABLE); drive(4'b0000, 7'd0, 1);
        drive(4'b0010, p1, STABLE); drive(4'b0000, 7'd0, 1);
        drive(4'b0100, p2, STABLE); drive(4'b0000, 7'd0, 1);
        drive(4'b1000, p3, STABLE); drive(4'b0000, 7'd0, 2);
    endtask

    task automatic pulse_reset();
        w_rst = 1'b1;
        w_sel = '0;
        @(posedge w_clk);
        #1;
        w_rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rsel;
        logic [6:0] rseg;
        pat_tab[0]  = 7'b1111110; pat_tab[1]  = 7'b0110000;
        pat_tab[2]  = 7'b1101101; pat_tab[3]  = 7'b1111001;
        pat_tab[4]  = 7'b0110011; pat_tab[5]  = 7'b1011011;
        pat_tab[6]  = 7'b1011111; pat_tab[7]  = 7'b1110000;
        pat_tab[8]  = 7'b1111111; pat_tab[9]  = 7'b1111011;
        pat_tab[10] = 7'b1110111; pat_tab[11] = 7'b0011111;
        pat_tab[12] = 7'b1001110; pat_tab[13] = 7'b0111101;
        pat_tab[14] = 7'b1001111; pat_tab[15] = 7'b1000111;

        w_rst = 1'b1;
        w_sel = '0;
        w_seg = '0;
        repeat (2) @(posedge w_clk);
        #1;
        w_rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_val",   32'(w_val),   32'h0);
        chk("rst_err",   32'(w_err),   32'h0);
        chk("rst_blank", 32'(w_blank), 32'h0);
        chk("rst_frame", 32'(w_frame), 32'h0);

        // Single digit held exactly STABLE cycles
        drive(4'b0001, 7'b1111001, 3);
        drive(4'b0000, 7'd0, 2);
        chk("d0_val",     32'(w_val[3:0]), 32'h3);
        chk("d0_err",     32'(w_err[0]),   32'h0);
        chk("d0_blank",   32'(w_blank[0]), 32'h0);
        chk("d0_noframe", 32'(frame_seen), 32'd0);

        // Full scan 1,2,5,9 -> one frame
        scan(7'b0110000, 7'b1101101, 7'b1011011, 7'b1111011);
        chk("scan_val",   32'(w_val),      32'h9521);
        chk("scan_frame", 32'(frame_seen), 32'd1);

        // Two cycles of '1', one segment flips to '7', held 3 cycles
        drive(4'b0010, 7'b0110000, 2);
        drive(4'b0010, 7'b1110000, 3);
        drive(4'b0000, 7'd0, 2);
        chk("glitch_val", 32'(w_val[7:4]), 32'h7);

        // Blank pattern on digit 2
        drive(4'b0100, 7'b0000000, 3);
        drive(4'b0000, 7'd0, 2);
        chk("blank_val", 32'(w_val[11:8]), 32'hF);
        chk("blank_b",   32'(w_blank[2]),  32'h1);
        chk("blank_err", 32'(w_err[2]),    32'h0);

        // Letter A on digit 3
        drive(4'b1000, 7'b1110111, 3);
        drive(4'b0000, 7'd0, 2);
`ifdef SEG7_READER_HEX_EN
        chk("hexA_val", 32'(w_val[15:12]), 32'hA);
        chk("hexA_err", 32'(w_err[3]),     32'h0);
`else
        chk("hexA_val", 32'(w_val[15:12]), 32'hF);
        chk("hexA_err", 32'(w_err[3]),     32'h1);
`endif

        // Two selects at once never capture
        drive(4'b0011, 7'b1111111, 10);
        drive(4'b0000, 7'd0, 2);
`ifdef SEG7_READER_HEX_EN
        chk("multi_val", 32'(w_val), 32'hAF71);
`else
        chk("multi_val", 32'(w_val), 32'hFF71);
`endif
        chk("multi_frame", 32'(frame_seen), 32'd1);

        // Reset with digits 1..3 captured, then a fresh full scan
        pulse_reset();
        chk("mid_rst_val",   32'(w_val),   32'h0);
        chk("mid_rst_err",   32'(w_err),   32'h0);
        chk("mid_rst_blank", 32'(w_blank), 32'h0);
        scan(7'b0110000, 7'b1101101, 7'b1011011, 7'b1111011);
        chk("rescan_val",   32'(w_val),      32'h9521);
        chk("rescan_frame", 32'(frame_seen), 32'd2);

        // Randomized bus traffic
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 99) < 2) pulse_reset();
            case ($urandom_range(0, 9))
                7:       rsel = 4'b0000;
                8:       rsel = 4'($urandom_range(0, 15));
                default: rsel = 4'(1 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 5))
                0:       rseg = 7'($urandom_range(0, 127));
                1:       rseg = 7'b0000000;
                default: rseg = pat_tab[$urandom_range(0, 15)];
            endcase
            drive(rsel, rseg, $urandom_range(1, 5));
        end
        drive(4'b0000, 7'd0, STABLE + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
